// File: rtl/window_feeder_pkg.sv
// Shared constants and FSM encoding for the 3x3 window feeder.
// Imported by the feeder top and its line-buffer sub-module.
package window_feeder_pkg;

    localparam int CELL_BIT = 8;
    localparam int N_CELL   = 9;
    localparam int MAX_W    = 64;
    localparam int DIM_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/window_feeder_line_buffer.sv
// One-row delay line: shared read/write address, read returns the old word
// (read-before-write), so the same column can be read and overwritten in one cycle.
module line_buffer
    import window_feeder_pkg::*;
#(
    parameter int DEPTH = MAX_W,
    parameter int WIDTH = CELL_BIT,
    localparam int ADDR_BIT = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [ADDR_BIT-1:0] i_addr,
    input  logic [WIDTH-1:0]    i_wdata,
    output logic [WIDTH-1:0]    o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_feeder.sv
// Streams a raster-order frame through two row delay lines and emits every
// fully-populated 3x3 window, one cycle after the pixel that completes it.
module window_feeder
    import window_feeder_pkg::*;
#(
    parameter int CELL_BIT = window_feeder_pkg::CELL_BIT,
    parameter int N_CELL   = window_feeder_pkg::N_CELL,
    parameter int MAX_W    = window_feeder_pkg::MAX_W,
    parameter int DIM_BIT  = window_feeder_pkg::DIM_BIT
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DIM_BIT-1:0]         i_img_width,
    input  logic [DIM_BIT-1:0]         i_img_height,
    input  logic [CELL_BIT-1:0]        i_in_pix,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic [CELL_BIT*N_CELL-1:0] o_win,
    output logic                       o_win_valid,
    output logic                       o_win_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_cfg_err
);

    localparam int ADDR_BIT = $clog2(MAX_W);

    fsm_state_e          r_state;
    fsm_state_e          w_next_state;
    logic [DIM_BIT-1:0]  r_width;
    logic [DIM_BIT-1:0]  r_height;
    logic [DIM_BIT-1:0]  r_row;
    logic [DIM_BIT-1:0]  r_col;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_err;
    logic                r_win_valid;
    logic                r_win_last;
    logic [CELL_BIT-1:0] r_cell [N_CELL];

    logic                w_dims_ok;
    logic                w_accept;
    logic                w_xfer;
    logic                w_col_wrap;
    logic                w_last_pix;
    logic [CELL_BIT-1:0] w_up1;
    logic [CELL_BIT-1:0] w_up2;

    assign w_dims_ok  = (i_img_width >= DIM_BIT'(3)) && (i_img_width <= DIM_BIT'(MAX_W))
                        && (i_img_height >= DIM_BIT'(3));
    assign w_accept   = (r_state == ST_IDLE) && i_start && w_dims_ok;
    assign w_xfer     = i_in_valid && r_in_ready;
    assign w_col_wrap = (r_col == (r_width - DIM_BIT'(1)));
    assign w_last_pix = w_col_wrap && (r_row == (r_height - DIM_BIT'(1)));

    // Row delay lines: u_lb_row1 holds the previous row, u_lb_row2 the one before it.
    line_buffer #(.DEPTH(MAX_W), .WIDTH(CELL_BIT)) u_lb_row1 (
        .i_clk   (i_clk),
        .i_we    (w_xfer),
        .i_addr  (r_col[ADDR_BIT-1:0]),
        .i_wdata (i_in_pix),
        .o_rdata (w_up1)
    );

    line_buffer #(.DEPTH(MAX_W), .WIDTH(CELL_BIT)) u_lb_row2 (
        .i_clk   (i_clk),
        .i_we    (w_xfer),
        .i_addr  (r_col[ADDR_BIT-1:0]),
        .i_wdata (w_up1),
        .o_rdata (w_up2)
    );

    // Next-state decode for the frame sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_xfer && w_last_pix) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, status flags, frame dimensions and raster position.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_width    <= '0;
            r_height   <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else begin
            r_state    <= w_next_state;
            // Flags are registered copies of the next-state decode.
            r_in_ready <= (w_next_state == ST_RUN);
            r_busy     <= (w_next_state != ST_IDLE);
            r_done     <= (w_next_state == ST_DONE);
            r_cfg_err  <= (r_state == ST_IDLE) && i_start && !w_dims_ok;
            if (w_accept) begin
                r_width  <= i_img_width;
                r_height <= i_img_height;
                r_row    <= '0;
                r_col    <= '0;
            end else if (w_xfer) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_BIT'(1);
                end else begin
                    r_col <= r_col + DIM_BIT'(1);
                end
            end
        end
    end

    // Window shift register: columns move left, newest column enters at c=2.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_CELL; k++) begin
                r_cell[k] <= '0;
            end
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else begin
            // The first two columns of a row only prime, so windows never span a wrap.
            r_win_valid <= w_xfer && (r_row >= DIM_BIT'(2)) && (r_col >= DIM_BIT'(2));
            r_win_last  <= w_xfer && w_last_pix;
            if (w_xfer) begin
                for (int r = 0; r < 3; r++) begin
                    r_cell[3*r]   <= r_cell[3*r+1];
                    r_cell[3*r+1] <= r_cell[3*r+2];
                end
                r_cell[2] <= w_up2;
                r_cell[5] <= w_up1;
                r_cell[8] <= i_in_pix;
            end
        end
    end

    for (genvar g = 0; g < N_CELL; g++) begin : g_win
        assign o_win[CELL_BIT*g +: CELL_BIT] = r_cell[g];
    end

    assign o_in_ready  = r_in_ready;
    assign o_win_valid = r_win_valid;
    assign o_win_last  = r_win_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: frames of pixel value base+16*row+col,
// windows collected on the falling edge and compared with hand-derived values.
module tb_window_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  img_w = 7'd0;
    logic [6:0]  img_h = 7'd0;
    logic [7:0]  pix = 8'd0;
    logic        in_valid = 1'b0;
    logic        o_in_ready;
    logic [71:0] o_win;
    logic        o_win_valid;
    logic        o_win_last;
    logic        o_busy;
    logic        o_done;
    logic        o_cfg_err;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int t22 = 0;
    int done_cnt = 0;
    int done_with_last = 0;
    int err_cnt = 0;
    int ready_seen = 0;
    logic [71:0] cap_win [$];
    logic        cap_last [$];
    int          cap_cyc [$];

    localparam logic [71:0] FIRST_4X4 = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] LAST_4X4  = 72'h33_32_31_23_22_21_13_12_11;

    window_feeder dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_img_width  (img_w),
        .i_img_height (img_h),
        .i_in_pix     (pix),
        .i_in_valid   (in_valid),
        .o_in_ready   (o_in_ready),
        .o_win        (o_win),
        .o_win_valid  (o_win_valid),
        .o_win_last   (o_win_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cfg_err    (o_cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_win_valid) begin
            cap_win.push_back(o_win);
            cap_last.push_back(o_win_last);
            cap_cyc.push_back(cyc);
        end
        if (o_done) done_cnt = done_cnt + 1;
        if (o_done && o_win_last) done_with_last = done_with_last + 1;
        if (o_cfg_err) err_cnt = err_cnt + 1;
        if (o_in_ready) ready_seen = ready_seen + 1;
    end

    function automatic logic [7:0] pixv(input int base, input int r, input int c);
        return 8'(base + 16 * r + c);
    endfunction

    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[8*(3*i+j) +: 8] = pixv(base, r - 2 + i, c - 2 + j);
        return v;
    endfunction

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        img_w = 7'(w);
        img_h = 7'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int w, input int base, input bit gaps, input int npix);
        int idx = 0;
        int n = 0;
        while (idx < npix && n < 500) begin
            @(negedge clk);
            n++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                pix = pixv(base, idx / w, idx % w);
                if (o_in_ready) begin
                    if (idx == 2 * w + 2) t22 = cyc + 1;
                    idx++;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        vecs++;
        if (idx != npix) begin
            errs++;
            $display("FAIL feed_accept: accepted %0d pixels, required %0d", idx, npix);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if ({o_in_ready, o_win_valid, o_win_last, o_busy, o_done, o_cfg_err} !== 6'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b required 000000",
                     {o_in_ready, o_win_valid, o_win_last, o_busy, o_done, o_cfg_err});
        end
        vecs++;
        if (o_win !== 72'h0) begin
            errs++;
            $display("FAIL reset_win: got %h required 0", o_win);
        end
        reset = 1'b0;
    endtask

    task automatic test_4x4();
        int b = cap_win.size();
        int d = done_cnt;
        int dl = done_with_last;
        do_start(4, 4);
        vecs++;
        if ({o_busy, o_in_ready} !== 2'b11) begin
            errs++;
            $display("FAIL 4x4_run_entry: busy/ready %b required 11", {o_busy, o_in_ready});
        end
        feed(4, 0, 1'b0, 16);
        wait_done();
        @(negedge clk);
        vecs++;
        if (cap_win.size() - b != 4) begin
            errs++;
            $display("FAIL 4x4_count: got %0d windows required 4", cap_win.size() - b);
        end else begin
            vecs++;
            if (cap_win[b] !== FIRST_4X4 || cap_last[b] !== 1'b0) begin
                errs++;
                $display("FAIL 4x4_first: got %h last %b required %h last 0", cap_win[b], cap_last[b], FIRST_4X4);
            end
            vecs++;
            if (cap_cyc[b] != t22) begin
                errs++;
                $display("FAIL 4x4_latency: window at cycle %0d required %0d", cap_cyc[b], t22);
            end
            for (int k = 1; k < 3; k++) begin
                vecs++;
                if (cap_win[b+k] !== exp_win(0, 2 + k / 2, 2 + k % 2) || cap_last[b+k] !== 1'b0) begin
                    errs++;
                    $display("FAIL 4x4_mid%0d: got %h required %h", k, cap_win[b+k], exp_win(0, 2 + k / 2, 2 + k % 2));
                end
            end
            vecs++;
            if (cap_win[b+3] !== LAST_4X4 || cap_last[b+3] !== 1'b1) begin
                errs++;
                $display("FAIL 4x4_last: got %h last %b required %h last 1", cap_win[b+3], cap_last[b+3], LAST_4X4);
            end
        end
        vecs++;
        if (done_cnt - d != 1 || done_with_last - dl != 1) begin
            errs++;
            $display("FAIL 4x4_done: %0d pulses (%0d with win_last) required 1 (1)", done_cnt - d, done_with_last - dl);
        end
        vecs++;
        if (o_win_valid !== 1'b0 || o_win !== LAST_4X4 || o_busy !== 1'b0) begin
            errs++;
            $display("FAIL 4x4_hold: valid %b busy %b win %h required 0 0 %h", o_win_valid, o_busy, o_win, LAST_4X4);
        end
    endtask

    task automatic test_3x3();
        int b = cap_win.size();
        int d = done_cnt;
        do_start(3, 3);
        feed(3, 0, 1'b0, 9);
        wait_done();
        vecs++;
        if ({o_done, o_win_valid, o_win_last} !== 3'b111) begin
            errs++;
            $display("FAIL 3x3_final: done/valid/last %b required 111", {o_done, o_win_valid, o_win_last});
        end
        start = 1'b1;
        img_w = 7'd3;
        img_h = 7'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vecs++;
        if ({o_busy, o_in_ready} !== 2'b00) begin
            errs++;
            $display("FAIL 3x3_start_in_done: busy/ready %b required 00", {o_busy, o_in_ready});
        end
        vecs++;
        if (cap_win.size() - b != 1 || done_cnt - d != 1) begin
            errs++;
            $display("FAIL 3x3_count: %0d windows %0d done required 1 1", cap_win.size() - b, done_cnt - d);
        end else begin
            vecs++;
            if (cap_win[b] !== FIRST_4X4 || cap_last[b] !== 1'b1) begin
                errs++;
                $display("FAIL 3x3_win: got %h last %b required %h last 1", cap_win[b], cap_last[b], FIRST_4X4);
            end
        end
    endtask

    task automatic test_cfg_err();
        int widths [2] = '{2, 65};
        for (int t = 0; t < 2; t++) begin
            int e = err_cnt;
            int r = ready_seen;
            do_start(widths[t], 4);
            vecs++;
            if (o_cfg_err !== 1'b1) begin
                errs++;
                $display("FAIL cfg_err_timing_w%0d: got %b required 1", widths[t], o_cfg_err);
            end
            repeat (3) @(negedge clk);
            vecs++;
            if (err_cnt - e != 1 || ready_seen - r != 0 || o_busy !== 1'b0) begin
                errs++;
                $display("FAIL cfg_err_w%0d: pulses %0d ready %0d busy %b required 1 0 0",
                         widths[t], err_cnt - e, ready_seen - r, o_busy);
            end
        end
    endtask

    task automatic test_5x4_gaps();
        int b1 = cap_win.size();
        int b2;
        do_start(5, 4);
        feed(5, 0, 1'b0, 20);
        wait_done();
        @(negedge clk);
        b2 = cap_win.size();
        do_start(5, 4);
        feed(5, 0, 1'b1, 20);
        wait_done();
        @(negedge clk);
        vecs++;
        if (b2 - b1 != 6 || cap_win.size() - b2 != 6) begin
            errs++;
            $display("FAIL 5x4_count: got %0d and %0d windows required 6 and 6", b2 - b1, cap_win.size() - b2);
        end else begin
            for (int k = 0; k < 6; k++) begin
                vecs++;
                if (cap_win[b2+k] !== cap_win[b1+k] || cap_win[b2+k] !== exp_win(0, 2 + k / 3, 2 + k % 3)
                    || cap_last[b2+k] !== (k == 5)) begin
                    errs++;
                    $display("FAIL 5x4_win%0d: gapped %h gap-free %h required %h", k,
                             cap_win[b2+k], cap_win[b1+k], exp_win(0, 2 + k / 3, 2 + k % 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        int d;
        do_start(4, 4);
        feed(4, 0, 1'b0, 7);
        d = done_cnt;
        reset = 1'b1;
        #1;
        vecs++;
        if ({o_in_ready, o_win_valid, o_win_last, o_busy, o_done, o_cfg_err} !== 6'b0 || o_win !== 72'h0) begin
            errs++;
            $display("FAIL reset_mid: flags %b win %h required 000000 0",
                     {o_in_ready, o_win_valid, o_win_last, o_busy, o_done, o_cfg_err}, o_win);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        b = cap_win.size();
        do_start(4, 4);
        feed(4, 0, 1'b0, 16);
        wait_done();
        @(negedge clk);
        vecs++;
        if (cap_win.size() - b != 4 || done_cnt - d != 1) begin
            errs++;
            $display("FAIL reset_mid_recover: %0d windows %0d done required 4 1", cap_win.size() - b, done_cnt - d);
        end else begin
            for (int k = 0; k < 4; k++) begin
                vecs++;
                if (cap_win[b+k] !== exp_win(0, 2 + k / 2, 2 + k % 2)) begin
                    errs++;
                    $display("FAIL reset_mid_win%0d: got %h required %h", k, cap_win[b+k], exp_win(0, 2 + k / 2, 2 + k % 2));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b = cap_win.size();
        int d = done_cnt;
        do_start(4, 4);
        feed(4, 0, 1'b0, 16);
        wait_done();
        do_start(4, 4);
        vecs++;
        if (o_in_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_accept: in_ready %b required 1", o_in_ready);
        end
        feed(4, 128, 1'b0, 16);
        wait_done();
        @(negedge clk);
        vecs++;
        if (cap_win.size() - b != 8 || done_cnt - d != 2) begin
            errs++;
            $display("FAIL b2b_count: %0d windows %0d done required 8 2", cap_win.size() - b, done_cnt - d);
        end else begin
            for (int k = 0; k < 8; k++) begin
                int base = (k < 4) ? 0 : 128;
                int m = k % 4;
                vecs++;
                if (cap_win[b+k] !== exp_win(base, 2 + m / 2, 2 + m % 2) || cap_last[b+k] !== (m == 3)) begin
                    errs++;
                    $display("FAIL b2b_win%0d: got %h required %h", k, cap_win[b+k], exp_win(base, 2 + m / 2, 2 + m % 2));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_3x3();
        test_cfg_err();
        test_5x4_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
